// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Package     : fft_pkg
// Description : Shared sizing constants, sequencer state encoding, butterfly
//               op record and bit-reversal helper for the FFT sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package fft_pkg;

  localparam int N_POINTS = 8;
  localparam int LOG2N    = 3;
  localparam int TW_W     = LOG2N - 1;
  localparam int STAGE_W  = (LOG2N > 1) ? $clog2(LOG2N) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    COMPUTE = 3'd2,
    WAIT    = 3'd3,
    DRAIN   = 3'd4
  } seq_state_t;

  typedef struct packed {
    logic [LOG2N-1:0] a;
    logic [LOG2N-1:0] b;
    logic [TW_W-1:0]  tw;
  } bf_op_t;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] x);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = x[LOG2N-1-i];
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fft_bf_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : fft_bf_addr_gen
// Description : Combinational radix-2 DIF butterfly addressing:
//               (stage, op index) -> {a, b, twiddle index}.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_bf_addr_gen
  import fft_pkg::*;
(
  input  logic [STAGE_W-1:0] stage_i,
  input  logic [TW_W-1:0]    op_idx_i,
  output bf_op_t             op_o
);

  logic [LOG2N-1:0] w_span;
  logic [LOG2N-1:0] w_mask;
  logic [LOG2N-1:0] w_k;
  logic [LOG2N-1:0] w_pos;
  logic [LOG2N-1:0] w_a;

  // Spans are powers of two, so k%span and k/span reduce to masking.
  always_comb begin
    w_span  = LOG2N'(N_POINTS >> (int'(stage_i) + 1));
    w_mask  = w_span - 1'b1;
    w_k     = {1'b0, op_idx_i};
    w_pos   = w_k & w_mask;
    w_a     = ((w_k & ~w_mask) << 1) | w_pos;
    op_o.a  = w_a;
    op_o.b  = w_a | w_span;
    op_o.tw = TW_W'(w_pos << stage_i);
  end

endmodule
`default_nettype wire

// File: rtl/fft_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fft_stage_sequencer
// Description : Load / compute / drain control for an in-place radix-2 DIF
//               FFT on one shared pipelined butterfly. Optional statistics
//               counters are built when FFT_SEQ_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_stage_sequencer
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = 50,
  parameter int BF_LATENCY = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  in_ready_o,
  output logic                  buf_we_o,
  output logic [LOG2N-1:0]      buf_waddr_o,
  output logic [DATA_WIDTH-1:0] buf_wdata_o,
  output logic                  bf_valid_o,
  output logic [LOG2N-1:0]      bf_a_idx_o,
  output logic [LOG2N-1:0]      bf_b_idx_o,
  output logic [TW_W-1:0]       bf_tw_idx_o,
  output logic                  wb_we_o,
  output logic [LOG2N-1:0]      wb_a_idx_o,
  output logic [LOG2N-1:0]      wb_b_idx_o,
  output logic                  out_valid_o,
  output logic [LOG2N-1:0]      out_raddr_o,
  output logic                  out_last_o,
  input  logic                  out_ready_i,
  output logic                  busy_o
`ifdef FFT_SEQ_STATS_EN
  ,
  output logic [15:0]           frame_cnt_o,
  output logic [15:0]           stall_cnt_o
`endif
);

  localparam int WAIT_W = (BF_LATENCY > 1) ? $clog2(BF_LATENCY) : 1;
  localparam int WB_W   = 2 * LOG2N + 1;

  localparam logic [LOG2N-1:0]   c_cnt_last   = LOG2N'(N_POINTS - 1);
  localparam logic [TW_W-1:0]    c_op_last    = TW_W'(N_POINTS / 2 - 1);
  localparam logic [WAIT_W-1:0]  c_wait_last  = WAIT_W'(BF_LATENCY - 1);
  localparam logic [STAGE_W-1:0] c_stage_last = STAGE_W'(LOG2N - 1);

  seq_state_t         r_state;
  seq_state_t         w_state_nxt;
  logic [LOG2N-1:0]   r_load_cnt;
  logic [TW_W-1:0]    r_op_cnt;
  logic [STAGE_W-1:0] r_stage;
  logic [WAIT_W-1:0]  r_wait_cnt;
  logic [LOG2N-1:0]   r_drain_cnt;

  logic                  r_buf_we;
  logic [LOG2N-1:0]      r_buf_waddr;
  logic [DATA_WIDTH-1:0] r_buf_wdata;
  logic [WB_W-1:0]       r_wb [BF_LATENCY];

  logic   w_accept;
  logic   w_drain_hs;
  logic   w_drain_done;
  bf_op_t w_op;

  fft_bf_addr_gen u_addr_gen (
    .stage_i  (r_stage),
    .op_idx_i (r_op_cnt),
    .op_o     (w_op)
  );

  always_comb begin
    w_state_nxt  = r_state;
    in_ready_o   = (r_state == IDLE) || (r_state == LOAD);
    bf_valid_o   = (r_state == COMPUTE);
    out_valid_o  = (r_state == DRAIN);
    busy_o       = (r_state != IDLE);
    w_accept     = in_valid_i && in_ready_o;
    out_last_o   = out_valid_o && (r_drain_cnt == c_cnt_last);
    w_drain_hs   = out_valid_o && out_ready_i;
    w_drain_done = w_drain_hs && out_last_o;
    bf_a_idx_o   = bf_valid_o ? w_op.a  : '0;
    bf_b_idx_o   = bf_valid_o ? w_op.b  : '0;
    bf_tw_idx_o  = bf_valid_o ? w_op.tw : '0;
    out_raddr_o  = bitrev(r_drain_cnt);

    unique case (r_state)
      IDLE:    if (w_accept) w_state_nxt = LOAD;
      LOAD:    if (w_accept && (r_load_cnt == c_cnt_last)) w_state_nxt = COMPUTE;
      COMPUTE: if (r_op_cnt == c_op_last) w_state_nxt = WAIT;
      // The last write-back of a stage must land before the next stage reads.
      WAIT:    if (r_wait_cnt == c_wait_last)
                 w_state_nxt = (r_stage == c_stage_last) ? DRAIN : COMPUTE;
      DRAIN:   if (w_drain_done) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Counters are powers of two and wrap back to zero on their last step.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_load_cnt  <= '0;
      r_op_cnt    <= '0;
      r_stage     <= '0;
      r_wait_cnt  <= '0;
      r_drain_cnt <= '0;
      r_buf_we    <= 1'b0;
      r_buf_waddr <= '0;
      r_buf_wdata <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_buf_we <= w_accept;
      if (w_accept) begin
        r_buf_waddr <= r_load_cnt;
        r_buf_wdata <= in_data_i;
        r_load_cnt  <= r_load_cnt + 1'b1;
      end
      if (bf_valid_o) r_op_cnt <= r_op_cnt + 1'b1;
      if (r_state == WAIT) begin
        if (r_wait_cnt == c_wait_last) begin
          r_wait_cnt <= '0;
          r_stage    <= (r_stage == c_stage_last) ? '0 : r_stage + 1'b1;
        end else begin
          r_wait_cnt <= r_wait_cnt + 1'b1;
        end
      end
      if (w_drain_hs) r_drain_cnt <= r_drain_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < BF_LATENCY; i++) r_wb[i] <= '0;
    end else begin
      r_wb[0] <= {bf_valid_o, bf_a_idx_o, bf_b_idx_o};
      for (int i = 1; i < BF_LATENCY; i++) r_wb[i] <= r_wb[i-1];
    end
  end

  assign buf_we_o    = r_buf_we;
  assign buf_waddr_o = r_buf_waddr;
  assign buf_wdata_o = r_buf_wdata;
  assign {wb_we_o, wb_a_idx_o, wb_b_idx_o} = r_wb[BF_LATENCY-1];

`ifdef FFT_SEQ_STATS_EN
  logic [15:0] r_frame_cnt;
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_frame_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_drain_done) r_frame_cnt <= r_frame_cnt + 16'd1;
      if (out_valid_o && !out_ready_i && (r_stall_cnt != 16'hFFFF))
        r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign frame_cnt_o = r_frame_cnt;
  assign stall_cnt_o = r_stall_cnt;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_fft_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_stage_sequencer
// Description : Directed table-driven bench for fft_stage_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_stage_sequencer;
  import fft_pkg::*;

  localparam int DW  = 50;
  localparam int LAT = 4;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          in_valid_i = 1'b0;
  logic [DW-1:0] in_data_i = '0;
  logic          out_ready_i = 1'b0;
  logic          in_ready_o, buf_we_o, bf_valid_o, wb_we_o, out_valid_o, out_last_o, busy_o;
  logic [2:0]    buf_waddr_o, bf_a_idx_o, bf_b_idx_o, wb_a_idx_o, wb_b_idx_o, out_raddr_o;
  logic [1:0]    bf_tw_idx_o;
  logic [DW-1:0] buf_wdata_o;
`ifdef FFT_SEQ_STATS_EN
  logic [15:0]   frame_cnt_o, stall_cnt_o;
`endif

  fft_stage_sequencer #(.DATA_WIDTH(DW), .BF_LATENCY(LAT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_data_i(in_data_i),
    .in_ready_o(in_ready_o), .buf_we_o(buf_we_o), .buf_waddr_o(buf_waddr_o),
    .buf_wdata_o(buf_wdata_o), .bf_valid_o(bf_valid_o), .bf_a_idx_o(bf_a_idx_o),
    .bf_b_idx_o(bf_b_idx_o), .bf_tw_idx_o(bf_tw_idx_o), .wb_we_o(wb_we_o),
    .wb_a_idx_o(wb_a_idx_o), .wb_b_idx_o(wb_b_idx_o), .out_valid_o(out_valid_o),
    .out_raddr_o(out_raddr_o), .out_last_o(out_last_o), .out_ready_i(out_ready_i),
    .busy_o(busy_o)
`ifdef FFT_SEQ_STATS_EN
    , .frame_cnt_o(frame_cnt_o), .stall_cnt_o(stall_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic iv, ordy, rdy, busy, we;
    logic [2:0] waddr;
    logic bfv;
    logic [2:0] a, b;
    logic [1:0] tw;
    logic ov;
    logic [2:0] ra;
    logic last;
  } vec_t;

  vec_t tbl[$];
  int ops [12][3] = '{'{0,4,0}, '{1,5,1}, '{2,6,2}, '{3,7,3},
                      '{0,2,0}, '{1,3,2}, '{4,6,0}, '{5,7,2},
                      '{0,1,0}, '{2,3,0}, '{4,5,0}, '{6,7,0}};
  int drain_ord [8] = '{0,4,2,6,1,5,3,7};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic iv, ordy, rdy, bsy, we, input int waddr, input logic bfv,
                      input int a, b, tw, input logic ov, input int ra, input logic last);
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.rdy = rdy; v.busy = bsy; v.we = we; v.waddr = 3'(waddr);
    v.bfv = bfv; v.a = 3'(a); v.b = 3'(b); v.tw = 2'(tw);
    v.ov = ov; v.ra = 3'(ra); v.last = last;
    tbl.push_back(v);
  endtask

  task automatic step();
    @(posedge clk_i); #1;
  endtask

  task automatic load8();
    for (int i = 0; i < 8; i++) begin
      in_valid_i = 1'b1; in_data_i = DW'(64'h2000 + i);
      step();
    end
    in_valid_i = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int w = 0;
    while (!out_valid_o && w < 100) begin step(); w++; end
    chk({tag, " reach drain"}, 64'(out_valid_o), 64'd1);
  endtask

  task automatic drain(input string tag, input bit toggle, output int stalls);
    int h = 0;
    int c = 0;
    stalls = 0;
    while (h < 8 && c < 60) begin
      out_ready_i = toggle ? (c % 3 == 0) : 1'b1;
      @(negedge clk_i);
      chk($sformatf("%s valid c%0d", tag, c), 64'(out_valid_o), 64'd1);
      chk($sformatf("%s raddr c%0d", tag, c), 64'(out_raddr_o), 64'(drain_ord[h]));
      chk($sformatf("%s last c%0d", tag, c), 64'(out_last_o), 64'(h == 7));
      if (out_ready_i) h++; else stalls++;
      step();
      c++;
    end
    out_ready_i = 1'b0;
    chk({tag, " handshakes"}, 64'(h), 64'd8);
    @(negedge clk_i);
    chk({tag, " in_ready after"}, 64'({in_ready_o, out_valid_o, busy_o}), 64'b100);
    step();
  endtask

  initial begin
    int nwe, exp_addr, stalls, w, wb_seen;
    logic [63:0] exp_wb;

    // Frame 1: back-to-back load, full compute, unstalled drain, cycle by cycle.
    for (int r = 0; r < 8; r++)
      push(1, 1, 1, r != 0, r != 0, (r != 0) ? r - 1 : 0, 0, 0, 0, 0, 0, 0, 0);
    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < 4; k++)
        push(s == 0 && k < 2, 1, 0, 1, s == 0 && k == 0, 7, 1,
             ops[s*4+k][0], ops[s*4+k][1], ops[s*4+k][2], 0, 0, 0);
      for (int q = 0; q < LAT; q++)
        push(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    end
    for (int j = 0; j < 8; j++)
      push(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, drain_ord[j], j == 7);
    push(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    repeat (3) @(posedge clk_i);
    #1;
    chk("reset ctl", 64'({in_ready_o, busy_o, buf_we_o, bf_valid_o, wb_we_o, out_valid_o, out_last_o}),
        64'b1000000);
    chk("reset idx", 64'({buf_waddr_o, bf_a_idx_o, bf_b_idx_o, bf_tw_idx_o, wb_a_idx_o, wb_b_idx_o, out_raddr_o}),
        64'd0);
    chk("reset wdata", 64'(buf_wdata_o), 64'd0);
    rst_i = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      in_valid_i  = tbl[i].iv;
      in_data_i   = DW'(64'h1000 + i);
      out_ready_i = tbl[i].ordy;
      @(negedge clk_i);
      chk($sformatf("row%0d ctl", i), 64'({in_ready_o, busy_o}), 64'({tbl[i].rdy, tbl[i].busy}));
      chk($sformatf("row%0d buf_we", i), 64'(buf_we_o), 64'(tbl[i].we));
      if (tbl[i].we)
        chk($sformatf("row%0d buf addr/data", i), 64'({buf_waddr_o, buf_wdata_o}),
            64'({tbl[i].waddr, DW'(64'h1000 + i - 1)}));
      chk($sformatf("row%0d bf_valid", i), 64'(bf_valid_o), 64'(tbl[i].bfv));
      if (tbl[i].bfv)
        chk($sformatf("row%0d bf op", i), 64'({bf_a_idx_o, bf_b_idx_o, bf_tw_idx_o}),
            64'({tbl[i].a, tbl[i].b, tbl[i].tw}));
      exp_wb = (i >= LAT) ? 64'({tbl[i-LAT].bfv, tbl[i-LAT].a, tbl[i-LAT].b}) : 64'd0;
      chk($sformatf("row%0d wb_we", i), 64'(wb_we_o), 64'(exp_wb[6]));
      if (exp_wb[6])
        chk($sformatf("row%0d wb idx", i), 64'({wb_a_idx_o, wb_b_idx_o}), 64'(exp_wb[5:0]));
      chk($sformatf("row%0d drain ctl", i), 64'({out_valid_o, out_last_o}),
          64'({tbl[i].ov, tbl[i].last}));
      if (tbl[i].ov)
        chk($sformatf("row%0d raddr", i), 64'(out_raddr_o), 64'(tbl[i].ra));
      step();
    end
    in_valid_i = 1'b0;
    out_ready_i = 1'b0;

    // Frame 2: in_valid every other cycle, then drain with out_ready 1,0,0,...
    nwe = 0; exp_addr = 0;
    for (int c = 0; c < 24; c++) begin
      in_valid_i = (c % 2 == 0);
      in_data_i  = DW'(64'h3000 + c);
      @(negedge clk_i);
      if (buf_we_o) begin
        chk($sformatf("gap waddr %0d", nwe), 64'(buf_waddr_o), 64'(exp_addr));
        exp_addr++; nwe++;
      end
      step();
    end
    in_valid_i = 1'b0;
    chk("gap we count", 64'(nwe), 64'd8);
    wait_drain("f2");
    drain("f2", 1'b1, stalls);
    chk("f2 stall cycles", 64'(stalls), 64'd14);
`ifdef FFT_SEQ_STATS_EN
    chk("f2 stall_cnt", 64'(stall_cnt_o), 64'd14);
    chk("f2 frame_cnt", 64'(frame_cnt_o), 64'd2);
`endif

    // Frame 3: reset at stage 1 op 2, then a clean frame.
    load8();
    w = 0;
    @(negedge clk_i);
    while (!(bf_valid_o && bf_a_idx_o == 3'd4 && bf_b_idx_o == 3'd6) && w < 60) begin
      @(negedge clk_i); w++;
    end
    chk("found stage1 op2", 64'({bf_valid_o, bf_tw_idx_o}), 64'b100);
    rst_i = 1'b1;
    #1;
    chk("abort ctl", 64'({busy_o, in_ready_o, bf_valid_o, wb_we_o, out_valid_o}), 64'b01000);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    wb_seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      if (wb_we_o || busy_o) wb_seen++;
      step();
    end
    chk("no wb/busy after abort", 64'(wb_seen), 64'd0);
    load8();
    wait_drain("f4");
    drain("f4", 1'b0, stalls);
`ifdef FFT_SEQ_STATS_EN
    chk("f4 frame_cnt", 64'(frame_cnt_o), 64'd1);
    chk("f4 stall_cnt", 64'(stall_cnt_o), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
